// File: rtl/sram_emulator_monitor.sv
// sram_emulator_monitor: parametrised SRAM emulator with built-in write tracking
// (per-word write coverage, out-of-region detection, rewrite detection).
// Optional feature macro: SRAM_EXPECT_CHECK_EN adds the SRAM_expected array and
// the mismatch_count / first_mismatch_addr outputs.
module sram_emulator_monitor #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WR_LO        = 146944,
  parameter int unsigned WR_HI        = 262143
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic [ADDR_W-1:0] SRAM_address,
  input  logic [DATA_W-1:0] SRAM_write_data,
  output logic [DATA_W-1:0] SRAM_read_data,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic              clear_stats,
  output logic              ready,
  output logic [31:0]       write_count,
  output logic [31:0]       oor_count,
  output logic [31:0]       rewrite_count,
  output logic [ADDR_W-1:0] first_oor_addr,
  output logic [ADDR_W:0]   unwritten_count
`ifdef SRAM_EXPECT_CHECK_EN
  ,
  output logic [31:0]       mismatch_count,
  output logic [ADDR_W-1:0] first_mismatch_addr
`endif
);

  localparam int unsigned   DEPTH        = 2 ** ADDR_W;
  localparam int unsigned   HALF         = DATA_W / 2;
  localparam int unsigned   REGION_INT   = WR_HI - WR_LO + 1;
  localparam logic [ADDR_W:0] REGION_WORDS = REGION_INT[ADDR_W:0];
  localparam logic [ADDR_W:0] LO_ADDR      = {1'b0, WR_LO[ADDR_W-1:0]};

  typedef enum logic {S_CLEAR, S_ARMED} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q;
  logic [DATA_W-1:0] SRAM_data [DEPTH];
  logic              written   [DEPTH];
  logic [DATA_W-1:0] rd_pipe   [READ_LATENCY+1];

`ifdef SRAM_EXPECT_CHECK_EN
  logic [DATA_W-1:0] SRAM_expected [DEPTH];
  logic              mismatch;
`endif

  logic              wr_accept, rd_accept, count_write, in_region;
  logic [ADDR_W:0]   offset;

  assign wr_accept   = ~SRAM_CE_N & ~SRAM_WE_N & (~SRAM_UB_N | ~SRAM_LB_N);
  assign rd_accept   = ~SRAM_CE_N &  SRAM_WE_N & ~SRAM_OE_N;
  assign count_write = wr_accept & (state_q == S_ARMED) & ~clear_stats;

  // Addresses below WR_LO borrow into a value >= 2**ADDR_W, so one compare covers both bounds.
  assign offset    = {1'b0, SRAM_address} - LO_ADDR;
  assign in_region = (offset < REGION_WORDS);

`ifdef SRAM_EXPECT_CHECK_EN
  assign mismatch =
    (~SRAM_UB_N & (SRAM_write_data[DATA_W-1:HALF] != SRAM_expected[SRAM_address][DATA_W-1:HALF])) |
    (~SRAM_LB_N & (SRAM_write_data[HALF-1:0]      != SRAM_expected[SRAM_address][HALF-1:0]));
`endif

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // State register.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Resetn) state_q <= S_CLEAR;
    else         state_q <= state_d;
  end

  // Next-state logic: sweep finishes on the last address; clear_stats restarts it from anywhere.
  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned and infers a latch.
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      S_CLEAR: if (sweep_q == '1) state_d = S_ARMED;
      S_ARMED: ready = 1'b1;
      default: state_d = S_CLEAR;
    endcase
    if (clear_stats) state_d = S_CLEAR;
  end

  // Sweep counter walks the bitmap once per clear.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn)                 sweep_q <= '0;
    else if (clear_stats)        sweep_q <= '0;
    else if (state_q == S_CLEAR) sweep_q <= sweep_q + 1'b1;
  end

  // Data array: byte-lane writes in every state.
  always_ff @(posedge Clock_50) begin
    // NOTE: memories carry no reset; contents survive reset and the bench preloads them.
    if (wr_accept) begin
      if (!SRAM_UB_N) SRAM_data[SRAM_address][DATA_W-1:HALF] <= SRAM_write_data[DATA_W-1:HALF];
      if (!SRAM_LB_N) SRAM_data[SRAM_address][HALF-1:0]      <= SRAM_write_data[HALF-1:0];
    end
  end

  // Written bitmap: zeroed by the sweep, set by the first counted in-region write.
  always_ff @(posedge Clock_50) begin
    if (state_q == S_CLEAR)         written[sweep_q]      <= 1'b0;
    else if (count_write && in_region) written[SRAM_address] <= 1'b1;
  end

  // Read pipeline: data is captured at the sample edge, so a read right after a write sees it.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i <= int'(READ_LATENCY); i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= rd_accept ? SRAM_data[SRAM_address] : '0;
      for (int i = 1; i <= int'(READ_LATENCY); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign SRAM_read_data = rd_pipe[READ_LATENCY];

  // Write statistics; clear_stats wins over a simultaneous write.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn || clear_stats) begin
      write_count     <= '0;
      oor_count       <= '0;
      rewrite_count   <= '0;
      first_oor_addr  <= '0;
      unwritten_count <= REGION_WORDS;
`ifdef SRAM_EXPECT_CHECK_EN
      mismatch_count      <= '0;
      first_mismatch_addr <= '0;
`endif
    end else if (count_write) begin
      write_count <= sat_inc(write_count);
      if (!in_region) begin
        oor_count <= sat_inc(oor_count);
        if (oor_count == '0) first_oor_addr <= SRAM_address;
      end else if (written[SRAM_address]) begin
        rewrite_count <= sat_inc(rewrite_count);
      end else if (unwritten_count != '0) begin
        unwritten_count <= unwritten_count - 1'b1;
      end
`ifdef SRAM_EXPECT_CHECK_EN
      if (mismatch) begin
        mismatch_count <= sat_inc(mismatch_count);
        if (mismatch_count == '0) first_mismatch_addr <= SRAM_address;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_emulator_monitor.sv
// tb_sram_emulator_monitor: directed + randomized bench for sram_emulator_monitor,
// checked against a behavioural model of storage, statistics and read latency.
module tb_sram_emulator_monitor;

  localparam int AW     = 4;
  localparam int DW     = 16;
  localparam int RL     = 3;
  localparam int LO     = 4;
  localparam int HI     = 13;
  localparam int DEPTH  = 1 << AW;
  localparam int REGION = HI - LO + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          ub_n = 1'b1, lb_n = 1'b1, we_n = 1'b1, ce_n = 1'b1, oe_n = 1'b1;
  logic          clear = 1'b0;
  logic          ready;
  logic [31:0]   write_count, oor_count, rewrite_count;
  logic [AW-1:0] first_oor_addr;
  logic [AW:0]   unwritten_count;
`ifdef SRAM_EXPECT_CHECK_EN
  logic [31:0]   mismatch_count;
  logic [AW-1:0] first_mismatch_addr;
`endif

  always #5 clk = ~clk;

  sram_emulator_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .WR_LO(LO), .WR_HI(HI)
  ) dut (
    .Clock_50        (clk),
    .Resetn          (rst_n),
    .SRAM_address    (addr),
    .SRAM_write_data (wdata),
    .SRAM_read_data  (rdata),
    .SRAM_UB_N       (ub_n),
    .SRAM_LB_N       (lb_n),
    .SRAM_WE_N       (we_n),
    .SRAM_CE_N       (ce_n),
    .SRAM_OE_N       (oe_n),
    .clear_stats     (clear),
    .ready           (ready),
    .write_count     (write_count),
    .oor_count       (oor_count),
    .rewrite_count   (rewrite_count),
    .first_oor_addr  (first_oor_addr),
    .unwritten_count (unwritten_count)
`ifdef SRAM_EXPECT_CHECK_EN
    ,
    .mismatch_count      (mismatch_count),
    .first_mismatch_addr (first_mismatch_addr)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model.
  logic [15:0]   m_mem [DEPTH];
  bit            m_written [DEPTH];
  int unsigned   m_writes, m_oor, m_rewrite, m_unwritten;
  logic [AW-1:0] m_first_oor;
  int            m_clear_left;
  bit            m_armed;
  logic [15:0]   m_rd_q [$];
  logic [15:0]   m_rd_out;
`ifdef SRAM_EXPECT_CHECK_EN
  logic [15:0]   m_exp [DEPTH];
  int unsigned   m_mismatch;
  logic [AW-1:0] m_first_mm;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_clear_stats();
    m_writes = 0; m_oor = 0; m_rewrite = 0; m_first_oor = '0;
    m_unwritten = REGION; m_clear_left = DEPTH; m_armed = 0;
    foreach (m_written[i]) m_written[i] = 0;
`ifdef SRAM_EXPECT_CHECK_EN
    m_mismatch = 0; m_first_mm = '0;
`endif
  endtask

  task automatic model_reset();
    model_clear_stats();
    m_rd_q.delete();
    for (int i = 0; i < RL; i++) m_rd_q.push_back(16'h0);
    m_rd_out = 16'h0;
  endtask

  // One rising edge of the model, using the inputs currently driven.
  task automatic model_edge();
    bit wr_acc, rd_acc;
    int a;
    a      = int'(addr);
    wr_acc = !ce_n && !we_n && (!ub_n || !lb_n);
    rd_acc = !ce_n && we_n && !oe_n;
    m_rd_q.push_back(rd_acc ? m_mem[a] : 16'h0);
    m_rd_out = m_rd_q.pop_front();
    if (clear) begin
      model_clear_stats();
    end else if (m_armed && wr_acc) begin
      m_writes = sat(m_writes);
      if (a < LO || a > HI) begin
        if (m_oor == 0) m_first_oor = addr;
        m_oor = sat(m_oor);
      end else if (m_written[a]) begin
        m_rewrite = sat(m_rewrite);
      end else begin
        m_written[a] = 1;
        m_unwritten--;
      end
`ifdef SRAM_EXPECT_CHECK_EN
      if ((!ub_n && wdata[15:8] != m_exp[a][15:8]) || (!lb_n && wdata[7:0] != m_exp[a][7:0])) begin
        if (m_mismatch == 0) m_first_mm = addr;
        m_mismatch = sat(m_mismatch);
      end
`endif
    end else if (!m_armed) begin
      m_clear_left--;
      if (m_clear_left == 0) m_armed = 1;
    end
    if (wr_acc) begin
      if (!ub_n) m_mem[a][15:8] = wdata[15:8];
      if (!lb_n) m_mem[a][7:0]  = wdata[7:0];
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".rdata"},     rdata,           m_rd_out);
    check({tag, ".ready"},     ready,           m_armed);
    check({tag, ".writes"},    write_count,     m_writes);
    check({tag, ".oor"},       oor_count,       m_oor);
    check({tag, ".rewrite"},   rewrite_count,   m_rewrite);
    check({tag, ".first_oor"}, first_oor_addr,  m_first_oor);
    check({tag, ".unwritten"}, unwritten_count, m_unwritten);
`ifdef SRAM_EXPECT_CHECK_EN
    check({tag, ".mismatch"},  mismatch_count,      m_mismatch);
    check({tag, ".first_mm"},  first_mismatch_addr, m_first_mm);
`endif
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic drive_idle();
    ce_n = 1; we_n = 1; oe_n = 1; ub_n = 1; lb_n = 1; clear = 0;
  endtask

  task automatic drive_write(input int a, input logic [15:0] d, input logic ub, input logic lb);
    addr = a[AW-1:0]; wdata = d; ce_n = 0; we_n = 0; oe_n = 1; ub_n = ub; lb_n = lb;
  endtask

  task automatic drive_read(input int a);
    addr = a[AW-1:0]; ce_n = 0; we_n = 1; oe_n = 0; ub_n = 0; lb_n = 0;
  endtask

  // Read a word through the port and compare against a literal value.
  task automatic read_word(input string tag, input int a, input logic [15:0] exp);
    drive_read(a);
    step({tag, ".sample"});
    drive_idle();
    for (int i = 0; i < RL; i++) step({tag, ".lat"});
    check(tag, rdata, exp);
  endtask

  // Bounded wait for the sweep to finish; returns the number of cycles spent.
  task automatic wait_armed(input string tag, output int cycles);
    cycles = 0;
    drive_idle();
    while (ready !== 1'b1 && cycles < 4 * DEPTH) begin
      step(tag);
      cycles++;
    end
    check({tag, ".ready"}, ready, 1'b1);
  endtask

  initial begin
    int cyc;
    drive_idle();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 16'($urandom);
`ifdef SRAM_EXPECT_CHECK_EN
      m_exp[i] = 16'($urandom);
`endif
    end
    m_mem[5]  = 16'hABCD;
    m_mem[LO] = 16'hFFFF;
`ifdef SRAM_EXPECT_CHECK_EN
    m_exp[LO] = 16'h00FF;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      dut.SRAM_data[i] = m_mem[i];
`ifdef SRAM_EXPECT_CHECK_EN
      dut.SRAM_expected[i] = m_exp[i];
`endif
    end
    model_reset();

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    check("reset.unwritten_lit", unwritten_count, REGION);
    check("reset.ready_lit", ready, 1'b0);
    rst_n = 1;

    // Sweep lasts exactly DEPTH cycles.
    wait_armed("sweep", cyc);
    check("sweep.cycles", cyc, DEPTH);
    check("sweep.unwritten", unwritten_count, REGION);

    // Read latency: zero on the sample edge and the next two, data on the third.
    drive_read(5);
    step("rd5.e0");
    check("rd5.e0_zero", rdata, 16'h0);
    drive_idle();
    step("rd5.e1");
    check("rd5.e1_zero", rdata, 16'h0);
    step("rd5.e2");
    check("rd5.e2_zero", rdata, 16'h0);
    step("rd5.e3");
    check("rd5.e3_data", rdata, 16'hABCD);

    // Upper-lane write over 0xFFFF, then read back on the very next cycle.
    drive_write(LO, 16'h1234, 1'b0, 1'b1);
    step("ub_write");
    check("ub_write.count", write_count, 1);
    check("ub_write.unwritten", unwritten_count, REGION - 1);
    read_word("ub_write.readback", LO, 16'h12FF);

    // Rewrite and out-of-region on both sides of the window.
    drive_write(LO, 16'h0F0F, 1'b0, 1'b0);
    step("rewrite");
    drive_write(LO - 1, 16'h1111, 1'b0, 1'b0);
    step("oor_lo1");
    drive_write(LO - 1, 16'h2222, 1'b0, 1'b0);
    step("oor_lo2");
    check("oor.rewrite", rewrite_count, 1);
    check("oor.count", oor_count, 2);
    check("oor.first", first_oor_addr, LO - 1);
    drive_write(HI + 1, 16'h3333, 1'b1, 1'b0);
    step("oor_hi");
    drive_write(HI, 16'h4444, 1'b1, 1'b0);
    step("edge_hi");
    check("edge.oor", oor_count, 3);
    check("edge.first", first_oor_addr, LO - 1);
    check("edge.unwritten", unwritten_count, REGION - 2);
    check("edge.writes", write_count, 6);
    drive_idle();

    // Randomized traffic, including occasional clears.
    for (int n = 0; n < 400; n++) begin
      addr  = AW'($urandom);
      wdata = 16'($urandom);
      ce_n  = ($urandom_range(0, 7) == 0);
      we_n  = 1'($urandom);
      oe_n  = ($urandom_range(0, 4) == 0);
      ub_n  = 1'($urandom);
      lb_n  = 1'($urandom);
      clear = ($urandom_range(0, 59) == 0);
      step("rand");
    end

    // Clear on the same edge as a write: stats cleared, data stored.
    wait_armed("pre_clear", cyc);
    drive_write(HI, 16'h5555, 1'b0, 1'b0);
    clear = 1;
    step("clear_wr");
    clear = 0;
    check("clear_wr.writes", write_count, 0);
    check("clear_wr.oor", oor_count, 0);
    check("clear_wr.rewrite", rewrite_count, 0);
    check("clear_wr.first_oor", first_oor_addr, 0);
    check("clear_wr.ready", ready, 1'b0);
    check("clear_wr.unwritten", unwritten_count, REGION);
    read_word("clear_wr.readback", HI, 16'h5555);

    // A write during the sweep is stored but not counted.
    drive_write(LO + 1, 16'h6789, 1'b0, 1'b0);
    step("clear_sweep_wr");
    check("clear_sweep_wr.writes", write_count, 0);
    wait_armed("post_clear", cyc);
    read_word("clear_sweep_wr.readback", LO + 1, 16'h6789);

`ifdef SRAM_EXPECT_CHECK_EN
    drive_write(LO, 16'h01FF, 1'b0, 1'b0);
    step("expect");
    drive_idle();
    check("expect.count", mismatch_count, 1);
    check("expect.first", first_mismatch_addr, LO);
`endif

    drive_idle();
    step("tail");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_emulator_monitor.md
Name: sram_emulator_monitor

Overview:
Parametrised successor to the fixed 256K x 16 SRAM emulator used in the decompressor benches. It adds configurable geometry, configurable read latency, byte-lane writes, and built-in write tracking. Write tracking covers per-word write coverage, out-of-region detection and rewrite detection, so milestone benches no longer re-implement these in behavioural code. It sits beside the top-level UUT on the SRAM pins, in place of the old emulator.

Parameters:
ADDR_W, 18, address width; depth = 2**ADDR_W words
DATA_W, 16, word width; must be 16 (two byte lanes)
READ_LATENCY, 1, clocks from address sample to read data valid; legal range 1..4
WR_LO, 146944, lowest address legal for writes (inclusive)
WR_HI, 262143, highest address legal for writes (inclusive)

Ports:
Clock_50  in  1  clock, all logic on rising edge
Resetn  in  1  asynchronous active-low reset
SRAM_address  in  ADDR_W  word address
SRAM_write_data  in  DATA_W  write data
SRAM_read_data  out  DATA_W  read data
SRAM_UB_N  in  1  upper byte enable, active-low
SRAM_LB_N  in  1  lower byte enable, active-low
SRAM_WE_N  in  1  write enable, active-low
SRAM_CE_N  in  1  chip enable, active-low
SRAM_OE_N  in  1  output enable, active-low
clear_stats  in  1  one-cycle pulse; restarts the clear sweep
ready  out  1  high when the bitmap sweep is done and the monitor is armed
write_count  out  32  accepted write cycles
oor_count  out  32  writes outside [WR_LO, WR_HI]
rewrite_count  out  32  writes to an already-written word
first_oor_addr  out  ADDR_W  address of the first out-of-region write
unwritten_count  out  ADDR_W+1  in-region words never written

Behaviour:
- Storage: data array of 2**ADDR_W x DATA_W, not cleared by reset. The bench preloads it hierarchically through the array named SRAM_data. Separate 1-bit written bitmap of the same depth.
- FSM states:
  - S_CLEAR: sweep counter walks 0..2**ADDR_W-1, zeroing one bitmap bit per clock. Sweep duration is exactly 2**ADDR_W cycles.
  - S_ARMED: normal operation.
- Transitions:
  - Reset assertion forces S_CLEAR, with the sweep counter and all counters set to 0.
  - S_CLEAR goes to S_ARMED on the clock after the last address; ready rises in that cycle.
  - A clear_stats pulse in any state returns the FSM to S_CLEAR and zeroes all counters and first_oor_addr.
- Reset values: SRAM_read_data = 0, ready = 0, every counter = 0, first_oor_addr = 0, unwritten_count = WR_HI-WR_LO+1.
- Write definition: a write is accepted on a rising edge where CE_N=0, WE_N=0 and at least one of UB_N/LB_N is 0.
  - UB_N=0 writes bits [15:8]; LB_N=0 writes bits [7:0]; unselected lanes are unchanged.
  - Writes to storage happen in every state.
  - Statistics update only in S_ARMED; writes during S_CLEAR are stored but not counted.
- Statistics per accepted write in S_ARMED:
  - write_count increments by 1.
  - If the address is outside [WR_LO, WR_HI]: oor_count increments by 1. On the first such write (oor_count was 0), the address is latched into first_oor_addr. The bitmap is not touched.
  - Otherwise, if the bitmap bit is already set: rewrite_count increments by 1.
  - Otherwise: the bitmap bit is set and unwritten_count decrements by 1.
- Counters saturate at all-ones and never wrap.
- Read: a read is accepted on an edge where CE_N=0, WE_N=1 and OE_N=0.
  - The address is sampled on that edge; data appears on SRAM_read_data READ_LATENCY edges later.
  - The pipeline advances every cycle; an un-accepted cycle pushes 0 through it.
- Read-after-write to the same address on the next cycle returns the new data (write-first).
- Simultaneous clear_stats and write: the clear wins for statistics; the data is still stored.

Optional Feature:
SRAM_EXPECT_CHECK_EN:
- When defined, adds a second array SRAM_expected (preloaded by the bench), a mismatch_count output (32 bits, saturating) and a first_mismatch_addr output (ADDR_W).
- On each accepted S_ARMED write, every enabled lane is compared with the matching SRAM_expected lane; any difference increments mismatch_count.
- The first mismatch latches its address into first_mismatch_addr.
- When not defined, neither the ports nor the array exist.

Test Plan:
- Reset, then wait 2**ADDR_W cycles with ADDR_W=4 -> ready=0 for exactly 16 cycles, then 1. unwritten_count = WR_HI-WR_LO+1.
- Preload word 5 = 16'hABCD; read address 5 with READ_LATENCY=3 -> 16'hABCD appears on the third edge after sampling, 0 before.
- In S_ARMED, write 16'h1234 to address WR_LO with UB_N=0, LB_N=1, over a word holding 16'hFFFF -> word = 16'h12FF, write_count=1, unwritten_count decremented by 1.
- Write address WR_LO twice, then address WR_LO-1 twice -> rewrite_count=1, oor_count=2, first_oor_addr=WR_LO-1.
- Assert clear_stats on the same edge as a write of 16'h5555 to WR_HI -> all counters 0, FSM in S_CLEAR, word WR_HI = 16'h5555.
- With SRAM_EXPECT_CHECK_EN, expected word WR_LO = 16'h00FF, write 16'h01FF to WR_LO -> mismatch_count=1, first_mismatch_addr=WR_LO.
